// File: rtl/int_queue_reader_pkg.sv
// Shared types and constants for the interrupt queue reader.
package int_queue_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] SB_CNT_MAX = 8'd255;

endpackage

// File: rtl/int_queue_reader.sv
// Pops interrupt events from a FIFO, presents one at a time to software
// until acknowledged, and keeps ECC error and serviced-event statistics.
module int_queue_reader
  import int_queue_reader_pkg::*;
#(
  parameter int EVT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 fifoEmpty,
  output logic                 rdEn,
  input  logic [EVT_WIDTH-1:0] rdData,
  input  logic                 error_flag_sb_fifo,
  input  logic                 error_flag_db_fifo,
  input  logic                 intEn,
  input  logic                 clrReq,
  input  logic                 errClr,
  output logic                 statusValid,
  output logic [EVT_WIDTH-1:0] statusData,
  output logic                 statusDbErr,
  output logic                 intOut,
  output logic                 dbErrSticky,
  output logic [7:0]           sbErrCnt,
  output logic [CNT_WIDTH-1:0] evtCnt
);

  state_t state, stateNext;
  logic   fetch, ack;

  // Gated by resetn so no pop can leak out while reset is held.
  assign rdEn   = resetn && (state == IDLE) && !fifoEmpty;
  assign fetch  = (state == FETCH);
  assign ack    = (state == HOLD) && clrReq;
  assign intOut = statusValid && intEn;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (rdEn) stateNext = FETCH;
      FETCH:   stateNext = HOLD;
      HOLD:    if (clrReq) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      statusValid <= 1'b0;
      statusData  <= '0;
      statusDbErr <= 1'b0;
      dbErrSticky <= 1'b0;
      sbErrCnt    <= '0;
      evtCnt      <= '0;
    end else begin
      if (fetch) begin
        statusValid <= 1'b1;
        statusData  <= rdData;
        statusDbErr <= error_flag_db_fifo;
      end else if (ack) begin
        statusValid <= 1'b0;
      end

      // A same-cycle fetch error beats errClr so no event is lost.
      if (fetch && error_flag_sb_fifo) begin
        if (errClr)                       sbErrCnt <= 8'd1;
        else if (sbErrCnt != SB_CNT_MAX)  sbErrCnt <= sbErrCnt + 8'd1;
      end else if (errClr) begin
        sbErrCnt <= '0;
      end

      if (fetch && error_flag_db_fifo) dbErrSticky <= 1'b1;
      else if (errClr)                 dbErrSticky <= 1'b0;

      if (ack) evtCnt <= evtCnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_int_queue_reader.sv
// Directed bench: FIFO model with registered read data, checks latency,
// ordering, ECC statistics, polling, reset during fetch and counter wrap.
module tb_int_queue_reader;

  localparam int EW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          fifoEmpty;
  logic          rdEn;
  logic [EW-1:0] rdData;
  logic          error_flag_sb_fifo, error_flag_db_fifo;
  logic          intEn, clrReq, errClr;
  logic          statusValid, statusDbErr, intOut, dbErrSticky;
  logic [EW-1:0] statusData;
  logic [7:0]    sbErrCnt;
  logic [CW-1:0] evtCnt;

  int tests  = 0;
  int failed = 0;

  // FIFO model storage
  logic [EW-1:0] memD [0:1023];
  logic          memS [0:1023];
  logic          memB [0:1023];
  int            wrIdx = 0;
  int            rdIdx = 0;
  logic [EW-1:0] rdReg = '0;
  logic          sbReg = 1'b0, dbReg = 1'b0;
  logic          sbForce = 1'b0, dbForce = 1'b0;
  int            rdCnt = 0;
  int            holdViol = 0;
  int            evtExp = 0;

  assign fifoEmpty          = (wrIdx == rdIdx);
  assign rdData             = rdReg;
  assign error_flag_sb_fifo = sbReg | sbForce;
  assign error_flag_db_fifo = dbReg | dbForce;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rdEn) begin
      rdReg <= memD[rdIdx];
      sbReg <= memS[rdIdx];
      dbReg <= memB[rdIdx];
      rdIdx <= rdIdx + 1;
      rdCnt <= rdCnt + 1;
    end
  end

  always @(negedge clock) begin
    if (rdEn && statusValid) holdViol <= holdViol + 1;
  end

  int_queue_reader #(.EVT_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .resetn(resetn), .fifoEmpty(fifoEmpty), .rdEn(rdEn),
    .rdData(rdData), .error_flag_sb_fifo(error_flag_sb_fifo),
    .error_flag_db_fifo(error_flag_db_fifo), .intEn(intEn), .clrReq(clrReq),
    .errClr(errClr), .statusValid(statusValid), .statusData(statusData),
    .statusDbErr(statusDbErr), .intOut(intOut), .dbErrSticky(dbErrSticky),
    .sbErrCnt(sbErrCnt), .evtCnt(evtCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [EW-1:0] d, input logic s, input logic b);
    memD[wrIdx] = d;
    memS[wrIdx] = s;
    memB[wrIdx] = b;
    wrIdx++;
  endtask

  task automatic waitValid(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (statusValid) break;
      cyc(1);
    end
    chk(tag, 32'(statusValid), 1);
  endtask

  task automatic ack();
    clrReq = 1'b1;
    cyc(1);
    clrReq = 1'b0;
    evtExp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; intEn = 1'b1; clrReq = 1'b0; errClr = 1'b0;

    // Reset: outputs quiet even with a non-empty FIFO
    push(8'hA5, 1'b0, 1'b0);
    cyc(2);
    chk("rst_rdEn",   32'(rdEn), 0);
    chk("rst_valid",  32'(statusValid), 0);
    chk("rst_data",   32'(statusData), 0);
    chk("rst_intOut", 32'(intOut), 0);
    chk("rst_sb",     32'(sbErrCnt), 0);
    chk("rst_db",     32'(dbErrSticky), 0);
    chk("rst_evt",    32'(evtCnt), 0);

    // Single event: rdEn at N, presented at N+2
    resetn = 1'b1;
    #1 chk("single_rdEn", 32'(rdEn), 1);
    cyc(1);
    chk("single_fetch_rdEn",  32'(rdEn), 0);
    chk("single_fetch_valid", 32'(statusValid), 0);
    cyc(1);
    chk("single_valid",  32'(statusValid), 1);
    chk("single_data",   32'(statusData), 32'h A5);
    chk("single_intOut", 32'(intOut), 1);
    ack();
    chk("single_clr_int", 32'(intOut), 0);
    chk("single_clr_sv",  32'(statusValid), 0);
    chk("single_evt",     32'(evtCnt), 1);
    chk("single_no_rd",   32'(rdEn), 0);

    // clrReq in IDLE is ignored
    clrReq = 1'b1; cyc(1); clrReq = 1'b0; cyc(1);
    chk("idle_clr_evt", 32'(evtCnt), 1);

    // Three queued events, back-to-back service
    push(8'h01, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitValid("three_wait");
      chk("three_data", 32'(statusData), 32'(i + 1));
      ack();
      if (i < 2) begin
        #1 chk("three_b2b_rdEn", 32'(rdEn), 1);
      end
    end
    cyc(3);
    chk("three_rdCnt", 32'(rdCnt), 4);
    chk("three_evt",   32'(evtCnt), 4);
    chk("three_hold",  32'(holdViol), 0);

    // Polling mode
    intEn = 1'b0;
    push(8'h5A, 1'b0, 1'b0);
    waitValid("poll_wait");
    chk("poll_data",   32'(statusData), 32'h5A);
    chk("poll_intOut", 32'(intOut), 0);
    ack();
    chk("poll_clr_sv", 32'(statusValid), 0);
    chk("poll_evt",    32'(evtCnt), 5);
    intEn = 1'b1;

    // Error flags outside FETCH are ignored
    sbForce = 1'b1; dbForce = 1'b1;
    cyc(3);
    sbForce = 1'b0; dbForce = 1'b0;
    chk("ign_sb", 32'(sbErrCnt), 0);
    chk("ign_db", 32'(dbErrSticky), 0);

    // 300 single-bit corrections saturate at 255
    for (int i = 0; i < 300; i++) push(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      waitValid("sb_wait");
      if (i == 0) chk("sb_first", 32'(sbErrCnt), 1);
      ack();
    end
    cyc(2);
    chk("sb_sat",    32'(sbErrCnt), 255);
    chk("sb_evt",    32'(evtCnt), 32'(evtExp % 16));
    chk("sb_no_db",  32'(dbErrSticky), 0);

    // Double-bit event, then errClr, then a clean fetch
    push(8'hC3, 1'b0, 1'b1);
    waitValid("db_wait");
    chk("db_status", 32'(statusDbErr), 1);
    chk("db_sticky", 32'(dbErrSticky), 1);
    ack();
    chk("db_hold", 32'(statusDbErr), 1);
    errClr = 1'b1; cyc(1); errClr = 1'b0;
    chk("clr_sb", 32'(sbErrCnt), 0);
    chk("clr_db", 32'(dbErrSticky), 0);
    push(8'h3C, 1'b0, 1'b0);
    waitValid("clean_wait");
    chk("clean_dbstat", 32'(statusDbErr), 0);
    chk("clean_data",   32'(statusData), 32'h3C);
    ack();

    // errClr colliding with a FETCH error: the fetch wins
    push(8'h77, 1'b1, 1'b1);
    #1 chk("col_rdEn", 32'(rdEn), 1);
    cyc(1);
    errClr = 1'b1; cyc(1); errClr = 1'b0;
    chk("col_sb", 32'(sbErrCnt), 1);
    chk("col_db", 32'(dbErrSticky), 1);
    ack();

    // Reset during FETCH discards the word
    push(8'h99, 1'b0, 1'b0);
    #1 chk("rf_rdEn", 32'(rdEn), 1);
    cyc(1);
    resetn = 1'b0;
    #1;
    chk("rf_valid", 32'(statusValid), 0);
    chk("rf_data",  32'(statusData), 0);
    chk("rf_sb",    32'(sbErrCnt), 0);
    chk("rf_db",    32'(dbErrSticky), 0);
    chk("rf_evt",   32'(evtCnt), 0);
    chk("rf_int",   32'(intOut), 0);
    cyc(2);
    resetn = 1'b1;
    cyc(5);
    chk("rf_after_valid", 32'(statusValid), 0);
    chk("rf_after_rdEn",  32'(rdEn), 0);

    // 17 acknowledged events wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) push(8'(8'hE0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      waitValid("wrap_wait");
      if (i == 16) chk("wrap_last_data", 32'(statusData), 32'hF0);
      ack();
    end
    chk("wrap_evt",  32'(evtCnt), 1);
    chk("wrap_hold", 32'(holdViol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
